// File: rtl/csel_merge2_sync.sv
// rtl/csel_merge2_sync.sv - two-input conditional merge serialising drive/free transactions onto one channel
module csel_merge2_sync #(
    parameter int          DW       = 32,
    parameter int unsigned FREE_DLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_drive0,
    input  logic          i_drive1,
    input  logic [DW-1:0] i_data0,
    input  logic [DW-1:0] i_data1,
    output logic          o_free0,
    output logic          o_free1,
    output logic          o_driveNext,
    output logic [DW-1:0] o_data,
    output logic          o_src,
    input  logic          i_freeNext,
    output logic          o_busy,
    output logic          o_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        FREE = 3'd4
    } state_t;

    localparam logic [3:0] DLY_INIT = 4'(FREE_DLY);

    state_t        state;
    state_t        stateNext;
    logic [1:0]    pend;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic          rrPtr;
    logic [3:0]    dlyCnt;
    logic          grantEn;
    logic          grantSel;
    logic          loadCnt;
    logic [1:0]    freeHit;
    logic [1:0]    capture;
    logic          dupErr;
    logic          freeErr;

    always_comb begin
        stateNext = state;
        grantEn   = 1'b0;
        grantSel  = 1'b0;
        loadCnt   = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    grantEn   = 1'b1;
                    grantSel  = (pend == 2'b11) ? ~rrPtr : pend[1];
                    stateNext = SEND;
                end
            end
            SEND: begin
                loadCnt   = i_freeNext;
                stateNext = i_freeNext ? HOLD : WAIT;
            end
            WAIT: begin
                if (i_freeNext) begin
                    loadCnt   = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (dlyCnt == 4'd0) begin
                    stateNext = FREE;
                end
            end
            FREE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A drive landing in its own FREE cycle re-arms the channel instead of being a duplicate.
    assign freeHit[0] = (state == FREE) && !o_src;
    assign freeHit[1] = (state == FREE) && o_src;
    assign capture[0] = i_drive0 && (!pend[0] || freeHit[0]);
    assign capture[1] = i_drive1 && (!pend[1] || freeHit[1]);
    assign dupErr     = (i_drive0 && !capture[0]) || (i_drive1 && !capture[1]);
    assign freeErr    = i_freeNext && !((state == SEND) || (state == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= 2'b00;
            buf0   <= '0;
            buf1   <= '0;
            rrPtr  <= 1'b0;
            dlyCnt <= 4'd0;
            o_data <= '0;
            o_src  <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            state <= stateNext;

            if (loadCnt) begin
                dlyCnt <= DLY_INIT;
            end else if ((state == HOLD) && (dlyCnt != 4'd0)) begin
                dlyCnt <= dlyCnt - 4'd1;
            end

            if (capture[0]) begin
                pend[0] <= 1'b1;
                buf0    <= i_data0;
            end else if (freeHit[0]) begin
                pend[0] <= 1'b0;
            end

            if (capture[1]) begin
                pend[1] <= 1'b1;
                buf1    <= i_data1;
            end else if (freeHit[1]) begin
                pend[1] <= 1'b0;
            end

            if (grantEn) begin
                o_data <= grantSel ? buf1 : buf0;
                o_src  <= grantSel;
                if (pend == 2'b11) begin
                    rrPtr <= grantSel;
                end
            end

            if (dupErr || freeErr) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_driveNext = (state == SEND);
    assign o_free0     = freeHit[0];
    assign o_free1     = freeHit[1];
    assign o_busy      = (state != IDLE);

endmodule

// File: doc/csel_merge2_sync.md
Name: csel_merge2_sync

Overview:
- Synchronous two-input conditional merge for the drive/free handshake used by the split stages; it is the converging counterpart of a 2-way select split.
- Collects drive requests from two upstream channels and serialises them onto one downstream channel, carrying captured data and a source tag.
- Returns free only to the upstream channel that was served.
- Sits at reconvergence points of the control path, such as the memory-access return path.

Parameters:
DW, 32, data width of each upstream payload and of o_data
FREE_DLY, 1, extra cycles between the downstream free and the upstream free, range 0..15; stands in for the fixed matched delay of the async stages

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_drive0  in  1  upstream 0 drive request, single-cycle pulse
i_drive1  in  1  upstream 1 drive request, single-cycle pulse
i_data0  in  DW  upstream 0 payload, valid in the i_drive0 cycle
i_data1  in  DW  upstream 1 payload, valid in the i_drive1 cycle
o_free0  out  1  free returned to upstream 0, single-cycle pulse
o_free1  out  1  free returned to upstream 1, single-cycle pulse
o_driveNext  out  1  downstream drive, single-cycle pulse
o_data  out  DW  payload of the granted request
o_src  out  1  source of the granted request (0 or 1)
i_freeNext  in  1  downstream free, single-cycle pulse
o_busy  out  1  a transaction is in flight (state other than IDLE)
o_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: state IDLE; pend0 = pend1 = 0; RR pointer prefers input 0; delay counter = 0.
- Reset values of outputs: all outputs 0, including o_data and o_src.
- Reset mid-transaction drops the in-flight request silently; no free is emitted.
- Capture: i_driveX = 1 while pendX = 0 sets pendX and registers i_dataX into bufX on the same edge.
- Duplicate drive: i_driveX while pendX = 1 is ignored and sets o_err.
- States and transitions:
  - IDLE:
    - If exactly one pend is set, grant that input.
    - If both are set, grant the input opposite the RR pointer, then set the pointer to the granted input.
    - On grant, register o_data = bufG and o_src = G, and go to SEND.
  - SEND: o_driveNext = 1 for exactly this cycle. If i_freeNext = 1 in this cycle, go to HOLD; otherwise go to WAIT.
  - WAIT: stay until i_freeNext = 1, then go to HOLD with the counter loaded with FREE_DLY.
  - HOLD: decrement the counter each cycle; when it is 0, go to FREE. With FREE_DLY = 0, HOLD lasts one cycle.
  - FREE: o_freeG = 1 for exactly this cycle; clear pendG; go to IDLE.
- Data hold: o_data and o_src are held stable from SEND through FREE.
- Latency, with i_drive0 in cycle 0 and the block idle:
  - pend0 = 1 in cycle 1.
  - o_driveNext = 1 in cycle 2.
  - i_freeNext in cycle k (k ≥ 2) gives o_free0 in cycle k + 2 + FREE_DLY.
- Free ordering: free is never returned before i_freeNext. At most one o_free pulse per accepted drive.
- Simultaneous events:
  - Both drives in the same cycle are both captured; they are served in RR order, one complete transaction after the other.
  - i_driveG in the FREE cycle of G: the set wins. pendG stays 1 and is re-served from IDLE.
  - i_driveX (X not G) at any time while G is in flight: captured normally.
- Unexpected free: i_freeNext in IDLE, HOLD or FREE is ignored and sets o_err.
- o_err clears only on rst.
- Throughput: one transaction at a time; minimum 4 + FREE_DLY cycles per transaction.

Test Plan:
- Single request: FREE_DLY = 1; i_drive0 with i_data0 = 0xA5A5_0001 in cycle 0; i_freeNext in cycle 4 -> o_driveNext in cycle 2 with o_data = 0xA5A5_0001 and o_src = 0; o_free0 in cycle 7; o_free1 never asserts.
- Simultaneous requests: i_drive0 = i_drive1 = 1 in cycle 0 after reset; i_freeNext 2 cycles after each o_driveNext -> first grant is input 1 (pointer prefers 0, so the opposite is granted), second grant is input 0; exactly one o_free1 then one o_free0; data matches each source.
- Back-to-back and same-cycle free: input 1 drives every cycle that o_free1 pulses; i_freeNext in the same cycle as o_driveNext -> each drive is accepted with no o_err; HOLD is entered directly from SEND.
- Protocol errors: a second i_drive0 while pend0 = 1, then a stray i_freeNext in IDLE -> second drive ignored; no extra o_driveNext; o_err = 1 and stays 1 until rst.
- Reset mid-flight: rst asserted during WAIT -> next cycle all outputs 0, o_busy = 0, pend cleared; a fresh i_drive1 completes normally.
- Delay sweep: FREE_DLY = 0 and FREE_DLY = 15 -> o_free arrives exactly 2 and 17 cycles after i_freeNext respectively.
